// File: rtl/hazard_ctrl_id_ex.sv
// Load-use hazard detection and pipeline flow control at the ID/EX boundary.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl_id_ex #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic             EX_jump,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // The first stall cycle is spent in IDLE, so STALL covers the remainder.
    localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

    state_t     state_r;
    logic [3:0] rem_r;
    logic       hz_s;

    assign hz_s = ID_Valid & EX_MemRead & (EX_rt != 5'd0) &
                  ((EX_rt == ID_rs) | (ID_UsesRt & (EX_rt == ID_rt)));

    // Control outputs: reset forces the free-running values, jump beats stall.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Stalled      = 1'b0;
        if (!Reset_n) begin
            PCWrite      = 1'b1;
            IF_ID_Write  = 1'b1;
        end else if (EX_jump) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if ((state_r == ST_STALL) || hz_s) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
            Stalled      = 1'b1;
        end else begin
            Stalled      = 1'b0;
        end
    end

    // Stall sequencer: state plus remaining-cycle counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            rem_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (EX_jump) begin
                        state_r <= ST_IDLE;
                        rem_r   <= 4'd0;
                    end else if (hz_s && (STALL_CYCLES > 1)) begin
                        state_r <= ST_STALL;
                        rem_r   <= REM_INIT;
                    end else begin
                        state_r <= ST_IDLE;
                        rem_r   <= 4'd0;
                    end
                end
                ST_STALL: begin
                    if (EX_jump) begin
                        state_r <= ST_IDLE;
                        rem_r   <= 4'd0;
                    end else if (rem_r == 4'd1) begin
                        state_r <= ST_IDLE;
                        rem_r   <= 4'd0;
                    end else begin
                        state_r <= ST_STALL;
                        rem_r   <= rem_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rem_r   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating statistics counters.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, Stalled);
            flush_cnt_r <= sat_inc(flush_cnt_r, IF_ID_Flush);
        end
    end

    assign StallCount = stall_cnt_r;
    assign FlushCount = flush_cnt_r;
`else
    assign StallCount = {CNT_W{1'b0}};
    assign FlushCount = {CNT_W{1'b0}};
`endif

endmodule
